// File: rtl/multiplicador_secuencial_if.sv
// Handshake/data bundle for the sequential signed multiplier.
//   start    : request to begin a multiply (master -> slave)
//   A, B     : signed operands, sampled on the accept edge (master -> slave)
//   Producto : signed 2*WIDTH-bit product, held between operations (slave -> master)
//   busy     : operation in progress (slave -> master)
//   done     : one-cycle pulse when Producto has been updated (slave -> master)
interface multiplicador_secuencial_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   Producto;
  logic                 busy;
  logic                 done;

  modport master (
    output start, A, B,
    input  Producto, busy, done
  );

  modport slave (
    input  start, A, B,
    output Producto, busy, done
  );
endinterface

// File: rtl/multiplicador_secuencial.sv
// Sequential signed shift-add multiplier: Producto = A * B, one partial-product bit per clock.
// Operands are reduced to magnitudes on accept, multiplied unsigned, and the sign is applied
// in a final FIX cycle.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : multiplicador_secuencial_if.slave (start, A, B in; Producto, busy, done out)
// Optional feature: define MULT_EARLY_EXIT_EN to leave CALC as soon as the remaining
// multiplier magnitude is zero (data-dependent latency, identical results).
module multiplicador_secuencial #(
  parameter int unsigned WIDTH = 8
) (
  input logic                          clk,
  input logic                          rst,
  multiplicador_secuencial_if.slave    bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e               state_q;
  logic [2*WIDTH-1:0]   mag_a_q;   // multiplicand magnitude, pre-shifted by iteration index
  logic [WIDTH-1:0]     mag_b_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CntW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   producto_q;
  logic                 busy_q;
  logic                 done_q;

  // Two's-complement negation of the most negative value yields 2^(WIDTH-1) as unsigned,
  // which is exactly its magnitude, so no saturation is needed.
  logic [WIDTH-1:0]     mag_a_in;
  logic [WIDTH-1:0]     mag_b_in;
  logic                 calc_last;

  assign mag_a_in = bus.A[WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
  assign mag_b_in = bus.B[WIDTH-1] ? (~bus.B + 1'b1) : bus.B;

`ifdef MULT_EARLY_EXIT_EN
  assign calc_last = (cnt_q == CntW'(1)) || ((mag_b_q >> 1) == '0);
`else
  assign calc_last = (cnt_q == CntW'(1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      producto_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            mag_a_q <= {{WIDTH{1'b0}}, mag_a_in};
            mag_b_q <= mag_b_in;
            neg_q   <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            acc_q   <= '0;
            cnt_q   <= CntW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          if (mag_b_q[0]) begin
            acc_q <= acc_q + mag_a_q;
          end
          mag_a_q <= mag_a_q << 1;
          mag_b_q <= mag_b_q >> 1;
          cnt_q   <= cnt_q - CntW'(1);
          if (calc_last) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          // Negating zero gives zero, so no negative-zero special case.
          producto_q <= neg_q ? (~acc_q + 1'b1) : acc_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.Producto = producto_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Self-checking bench for multiplicador_secuencial: directed cases plus randomized operands,
// checked against plain signed arithmetic and the expected latency rule.
module tb_multiplicador_secuencial;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;

  multiplicador_secuencial_if #(.WIDTH(W)) bus ();

  multiplicador_secuencial #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed product in 2*W bits.
  function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    int p;
    logic [31:0] pv;
    sa = int'($signed(a));
    sb = int'($signed(b));
    p  = sa * sb;
    pv = p;
    return pv[2*W-1:0];
  endfunction

  // Reference: cycles from accept edge to done edge.
  function automatic int model_lat(input logic [W-1:0] b);
    int mb;
    int c;
    mb = int'($signed(b));
    if (mb < 0) mb = -mb;
    c = 1;
`ifdef MULT_EARLY_EXIT_EN
    while ((mb >> c) != 0) c++;
    return c + 1;
`else
    c = mb;  // unused in fixed-latency build
    return W + 1;
`endif
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    int lat;
    logic [2*W-1:0] exp;
    exp = model_prod(a, b);
    lat = model_lat(b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    n = 1;
    @(posedge clk);
    #1;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    check("producto", 32'(bus.Producto), 32'(exp));
    check("busy_after_done", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("producto_held", 32'(bus.Producto), 32'(exp));
  endtask

  initial begin
    int dones;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #12;
    check("rst_producto", 32'(bus.Producto), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(8'd7, 8'd6);
    run_op(-8'sd30, 8'd4);
    run_op(8'd56, -8'sd3);
    run_op(8'h80, 8'h80);
    run_op(8'h80, 8'd127);
    run_op(8'd0, -8'sd5);
    run_op(8'd100, 8'd1);
    run_op(8'd100, 8'hFF);

    // start while busy is ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'd5;
    bus.B     = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'd9;
    bus.B     = 8'd9;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        check("busy_drop_producto", 32'(bus.Producto), 32'h0019);
      end
    end
    check("busy_drop_dones", 32'(dones), 32'd1);

    // Asynchronous reset mid-operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = -8'sd4;
    bus.B     = 8'd2;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_producto", 32'(bus.Producto), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    run_op(8'd3, 8'd3);

    // Randomized operands with corner values mixed in
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = 8'h80;
        1:       ra = 8'd0;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 8'h80;
        1:       rb = 8'hFF;
        2:       rb = W'($urandom_range(0, 3));
        default: rb = W'($urandom);
      endcase
      run_op(ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
